// File: rtl/ara_inval_queue_pkg.sv
// Shared constants for the Ara invalidation queue.
package ara_inval_queue_pkg;

  localparam int unsigned CoalescedWidth = 16;
  localparam logic [CoalescedWidth-1:0] CoalescedMax = '1;

endpackage

// File: rtl/ara_inval_queue_cam.sv
// Entry storage for the invalidation queue: line registers, valid bits and
// a content-addressed lookup of the incoming line against occupied entries.
module ara_inval_queue_cam #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned Depth     = 4,
  parameter int unsigned PtrWidth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en,
  input  logic [PtrWidth-1:0]  wr_idx,
  input  logic [AddrWidth-1:0] wr_line,
  input  logic                 rd_en,
  input  logic [PtrWidth-1:0]  rd_idx,
  input  logic [AddrWidth-1:0] cmp_line,
  output logic [AddrWidth-1:0] head_line,
  output logic                 hit
);

  logic [AddrWidth-1:0] entry_reg [Depth];
  logic                 valid_reg [Depth];
  logic [Depth-1:0]     match_vec;
  logic [Depth-1:0]     excl_vec;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    // A write never targets the head while it is being popped; write wins anyway.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_reg[gi] <= '0;
        valid_reg[gi] <= 1'b0;
      end else if (wr_en && (wr_idx == PtrWidth'(gi))) begin
        entry_reg[gi] <= wr_line;
        valid_reg[gi] <= 1'b1;
      end else if (rd_en && (rd_idx == PtrWidth'(gi))) begin
        valid_reg[gi] <= 1'b0;
      end
    end

    assign match_vec[gi] = valid_reg[gi] && (entry_reg[gi] == cmp_line);
    // The departing head cannot absorb a new request.
    assign excl_vec[gi]  = rd_en && (rd_idx == PtrWidth'(gi));
  end

  assign hit       = |(match_vec & ~excl_vec);
  assign head_line = entry_reg[rd_idx];

endmodule

// File: rtl/ara_inval_queue.sv
// Coalescing invalidation queue between the AXI invalidation filter and
// Ariane's L1 D-cache invalidation port.
module ara_inval_queue
  import ara_inval_queue_pkg::*;
#(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned Depth       = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic [AddrWidth-1:0]         inval_addr_i,
  input  logic                         inval_valid_i,
  output logic                         inval_ready_o,
  output logic [AddrWidth-1:0]         inval_addr_o,
  output logic                         inval_valid_o,
  input  logic                         inval_ready_i,
  output logic [$clog2(Depth+1)-1:0]   usage_o,
  output logic [CoalescedWidth-1:0]    coalesced_o
);

  localparam int unsigned OffsetBits = $clog2(L1LineWidth);
  localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned UsageWidth = $clog2(Depth + 1);
  localparam logic [AddrWidth-1:0] LineMask =
      ~((AddrWidth'(1) << OffsetBits) - AddrWidth'(1));
  localparam logic [PtrWidth-1:0]   LastPtr  = PtrWidth'(Depth - 1);
  localparam logic [UsageWidth-1:0] FullCnt  = UsageWidth'(Depth);

  logic [PtrWidth-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [PtrWidth-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [UsageWidth-1:0]     count_reg, count_next;
  logic [CoalescedWidth-1:0] coalesced_reg, coalesced_next;

  logic [AddrWidth-1:0] line;
  logic [AddrWidth-1:0] head_line;
  logic hit, pop, push, coalesce, ready, accept;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  assign line = inval_addr_i & LineMask;

  ara_inval_queue_cam #(
    .AddrWidth (AddrWidth),
    .Depth     (Depth),
    .PtrWidth  (PtrWidth)
  ) i_cam (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en     (push),
    .wr_idx    (wr_ptr_reg),
    .wr_line   (line),
    .rd_en     (pop),
    .rd_idx    (rd_ptr_reg),
    .cmp_line  (line),
    .head_line (head_line),
    .hit       (hit)
  );

  always_comb begin
    pop      = (count_reg != '0) && inval_ready_i;
    // With coherence disabled every request is swallowed without effect.
    ready    = en_i ? (hit || (count_reg < FullCnt)) : 1'b1;
    accept   = en_i && inval_valid_i && ready;
    push     = accept && !hit;
    coalesce = accept && hit;

    rd_ptr_next    = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next    = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    count_next     = count_reg;
    coalesced_next = coalesced_reg;
    if (push && !pop) begin
      count_next = count_reg + UsageWidth'(1);
    end else if (!push && pop) begin
      count_next = count_reg - UsageWidth'(1);
    end
    if (coalesce && (coalesced_reg != CoalescedMax)) begin
      coalesced_next = coalesced_reg + CoalescedWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      coalesced_reg <= '0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      coalesced_reg <= coalesced_next;
    end
  end

  assign inval_ready_o = ready;
  assign inval_addr_o  = head_line;
  assign inval_valid_o = (count_reg != '0);
  assign usage_o       = count_reg;
  assign coalesced_o   = coalesced_reg;

endmodule

// File: tb/tb_ara_inval_queue.sv
// Randomized and directed bench for ara_inval_queue with a queue-based
// reference model and an output scoreboard.
module tb_ara_inval_queue;

  localparam int unsigned AW    = 64;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic [AW-1:0] inval_addr_i;
  logic          inval_valid_i;
  logic          inval_ready_o;
  logic [AW-1:0] inval_addr_o;
  logic          inval_valid_o;
  logic          inval_ready_i;
  logic [2:0]    usage_o;
  logic [15:0]   coalesced_o;

  int vectors = 0;
  int errors  = 0;
  bit verbose = 1'b1;

  logic [AW-1:0] mq [$];  // model contents, head first
  logic [AW-1:0] sb [$];  // expected output order
  int            coal;
  logic [AW-1:0] exp_addr;

  always #5 clk = ~clk;

  ara_inval_queue #(
    .AddrWidth   (AW),
    .L1LineWidth (16),
    .Depth       (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .inval_addr_i  (inval_addr_i),
    .inval_valid_i (inval_valid_i),
    .inval_ready_o (inval_ready_o),
    .inval_addr_o  (inval_addr_o),
    .inval_valid_o (inval_valid_o),
    .inval_ready_i (inval_ready_i),
    .usage_o       (usage_o),
    .coalesced_o   (coalesced_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: every pop must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_ni && inval_valid_o && inval_ready_i) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL pop_unexpected: got %h expected no output", inval_addr_o);
      end else begin
        exp_addr = sb.pop_front();
        check("pop_addr", inval_addr_o, exp_addr);
        if (verbose) $display("[%0t] pop addr=%h usage=%0d coalesced=%0d",
                              $time, inval_addr_o, usage_o, coalesced_o);
      end
    end
  end

  // One cycle: drive inputs, check state against the model, advance the model.
  task automatic step(input logic e, input logic [63:0] a, input logic v, input logic r);
    logic [63:0] line;
    bit hit, pop, rdy_exp;
    @(posedge clk);
    #1;
    en_i = e; inval_addr_i = a; inval_valid_i = v; inval_ready_i = r;
    #1;
    line = a & ~64'hF;
    pop  = (mq.size() != 0) && r;
    hit  = 1'b0;
    for (int i = (pop ? 1 : 0); i < mq.size(); i++)
      if (mq[i] == line) hit = 1'b1;
    rdy_exp = !e || hit || (mq.size() < DEPTH);
    check("ready", 64'(inval_ready_o), 64'(rdy_exp));
    check("valid", 64'(inval_valid_o), 64'(mq.size() != 0));
    check("usage", 64'(usage_o), 64'(mq.size()));
    check("coalesced", 64'(coalesced_o), 64'(coal));
    if (pop) void'(mq.pop_front());
    if (e && v && rdy_exp) begin
      if (hit) begin
        if (coal < 65535) coal++;
      end else begin
        mq.push_back(line);
        sb.push_back(line);
      end
    end
  endtask

  task automatic drain(input logic e);
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) step(e, 64'h0, 1'b0, 1'b1);
    step(e, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    coal = 0;
    rst_ni = 1'b1; en_i = 1'b1; inval_addr_i = '0; inval_valid_i = 1'b0; inval_ready_i = 1'b0;
    #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(inval_valid_o), 64'd0);
    check("rst_addr", inval_addr_o, 64'd0);
    check("rst_ready", 64'(inval_ready_o), 64'd1);
    check("rst_usage", 64'(usage_o), 64'd0);
    @(negedge clk) rst_ni = 1'b1;

    // Single request, popped as soon as it appears
    step(1, 64'h8000_1234, 1, 1);
    step(1, 64'h0, 0, 1);
    check("single_addr", inval_addr_o, 64'h8000_1230);
    step(1, 64'h0, 0, 1);

    // Coalescing within one line
    step(1, 64'h1000, 1, 0);
    step(1, 64'h1008, 1, 0);
    step(1, 64'h100F, 1, 0);
    step(1, 64'h0, 0, 0);
    check("coal_usage", 64'(usage_o), 64'd1);
    check("coal_count", 64'(coalesced_o), 64'd2);
    drain(1);

    // Full queue: hit still accepted, new line back-pressured
    step(1, 64'h000, 1, 0);
    step(1, 64'h010, 1, 0);
    step(1, 64'h020, 1, 0);
    step(1, 64'h030, 1, 0);
    step(1, 64'h034, 1, 0);
    step(1, 64'h040, 1, 0);
    check("full_block", 64'(inval_ready_o), 64'd0);
    step(1, 64'h040, 1, 1);
    step(1, 64'h040, 1, 1);
    drain(1);

    // Head exclusion: line being popped is re-enqueued
    step(1, 64'h200, 1, 0);
    c0 = coal;
    step(1, 64'h204, 1, 1);
    step(1, 64'h0, 0, 0);
    check("headx_addr", inval_addr_o, 64'h200);
    check("headx_coal", 64'(coalesced_o), 64'(c0));
    drain(1);

    // Enable gating
    step(1, 64'h300, 1, 0);
    step(0, 64'h400, 1, 0);
    check("en_ready", 64'(inval_ready_o), 64'd1);
    drain(0);

    // Asynchronous reset with entries queued
    step(1, 64'h600, 1, 0);
    step(1, 64'h610, 1, 0);
    step(1, 64'h620, 1, 0);
    step(1, 64'h0, 0, 0);
    #1 rst_ni = 1'b0;
    #1;
    check("mrst_valid", 64'(inval_valid_o), 64'd0);
    check("mrst_addr", inval_addr_o, 64'd0);
    check("mrst_usage", 64'(usage_o), 64'd0);
    check("mrst_coal", 64'(coalesced_o), 64'd0);
    check("mrst_ready", 64'(inval_ready_o), 64'd1);
    mq.delete(); sb.delete(); coal = 0;
    @(negedge clk) rst_ni = 1'b1;

    // Randomized traffic over a small line pool to force hits
    verbose = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] a;
      a = (64'($urandom_range(0, 7)) << 4) | 64'($urandom_range(0, 15))
        | (64'($urandom_range(0, 1)) << 40);
      step(($urandom_range(0, 9) != 0), a, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0);
    end
    drain(1);

    // Counter saturation
    step(1, 64'h500, 1, 0);
    for (int n = 0; n < 70000; n++) step(1, 64'h508, 1, 0);
    step(1, 64'h0, 0, 0);
    check("coal_sat", 64'(coalesced_o), 64'hFFFF);
    verbose = 1'b1;
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
